fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Shares the write side of one `fifo` instance between NUM_REQ requesters in the write-clock domain.
- Round-robin grants a burst of up to BURST_LEN words to one requester at a time.
- Throttles on the FIFO's `full_flag` and `almost_full_flag`.
- Drives the FIFO's `valid_write` and `data_in` from registers.

Parameters:
- SIZE, 8, data word width; matches the fifo SIZE.
- NUM_REQ, 4, number of requesters, 2..8.
- BURST_LEN, 4, maximum words accepted per grant, 1..16.

Ports:
- clock  input  1  write-side clock, same clock as the fifo `write_clock`.
- reset_n  input  1  asynchronous, active-low reset.
- request  input  NUM_REQ  per-requester word-pending; held until accepted.
- req_data  input  NUM_REQ*SIZE  packed words; requester i owns bits [i*SIZE +: SIZE]; stable while request[i] is high.
- full_flag  input  1  from the fifo.
- almost_full_flag  input  1  from the fifo; high means at most one free slot.
- accept  output  NUM_REQ  one-hot, combinational; pulses in the cycle the owner's word is taken.
- grant  output  NUM_REQ  one-hot registered burst owner; all zero in IDLE.
- valid_write  output  1  to the fifo `valid_write`; registered.
- write_data  output  SIZE  to the fifo `data_in`; registered.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release by the parent's aasd_reset):
  - state = IDLE, rr_ptr = 0, beat_count = 0.
  - grant = 0, valid_write = 0, write_data = 0, busy = 0.
- States:
  - IDLE: no owner.
  - BURST: owner granted, writes may issue.
  - HOLD: owner granted, FIFO blocking.
- Write permission: can_write = !full_flag && !(almost_full_flag && valid_write).
  - The second term covers the one registered write already in flight.
- IDLE:
  - If any request is high, pick the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Load grant one-hot, set beat_count = 0, go to BURST.
  - No accept is issued in IDLE, so every grant costs one arbitration cycle.
- BURST, accept[owner] = request[owner] && can_write. On accept:
  - write_data <= owner word and valid_write <= 1 at the next edge, giving 1-cycle latency from accept to the FIFO write.
  - beat_count increments.
  - If beat_count == BURST_LEN-1: rr_ptr <= owner+1 (mod NUM_REQ), grant <= 0, go to IDLE.
- BURST, otherwise:
  - valid_write <= 0 on any cycle with no accept.
  - If request[owner] is low: end the burst early; rr_ptr <= owner+1, go to IDLE.
  - If request[owner] is high and can_write is low: go to HOLD.
- HOLD:
  - accept = 0, valid_write = 0.
  - If request[owner] drops: rr_ptr <= owner+1, go to IDLE.
  - Else if can_write is high: go to BURST; the accept occurs in BURST, not in HOLD.
- Boundaries:
  - The FIFO never receives a write while `full_flag` is high.
  - Back-to-back writes at almost-full are prevented by can_write.
  - A single requester gets a new burst after one IDLE cycle.
  - The rr_ptr wrap from NUM_REQ-1 goes to 0.
  - A non-owner request is never accepted.
  - Reset mid-burst drops `valid_write` immediately (async); the in-flight word is discarded.

Optional Feature:
- Macro: FIFO_ARB_PRIORITY_EN.
- Defined: in IDLE, request[0] wins whenever high, regardless of rr_ptr. Requester 0's burst end does not advance rr_ptr. Other requesters keep round-robin among themselves.
- Undefined: pure round-robin as above.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum arb_state_t {IDLE, BURST, HOLD}.
  - REQ_IDX_W = $clog2(NUM_REQ) and BEAT_W = $clog2(BURST_LEN)+1 width helpers.
- Sub-module rr_select: combinational first-set-bit search from rr_ptr; returns index and found.

Test Plan:
- Single requester: request=4'b0001 with 6 words, FIFO empty. Requester 0 gets a burst of 4 writes on consecutive cycles, one IDLE cycle, then the remaining 2. Each `valid_write` follows its accept by 1 cycle.
- Round-robin fairness: all four requesters continuously requesting. Grant order 0,1,2,3,0; exactly 4 accepts per grant; rr_ptr wraps 3->0.
- Full throttle: `full_flag` forced high mid-burst after 2 beats. State goes to HOLD, accept=0 and valid_write=0 while full. On release, the burst resumes and finishes the remaining 2 beats.
- Almost-full: `almost_full_flag` high with one write in flight. No accept that cycle and no two consecutive writes; the FIFO never sees a write while full.
- Early release: the owner drops request after 1 beat. Return to IDLE the next cycle and the next requester is granted. Then assert reset_n=0 mid-burst: grant=0 and valid_write=0 immediately, and state is IDLE after release.
- With FIFO_ARB_PRIORITY_EN: requesters 1 and 0 pending with rr_ptr=1. Requester 0 is granted first and rr_ptr stays 1.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    HOLD
  } arb_state_t;

  // Index width for NUM_REQ requesters; never narrower than one bit.
  function automatic int unsigned req_idx_w(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Beat counter must hold BURST_LEN itself, hence the extra bit.
  function automatic int unsigned beat_w(input int unsigned burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin search: first set bit of req_i starting at ptr_i, wrapping.
module rr_select #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              found_o
);

  always_comb begin
    int unsigned pos;
    logic [IdxW-1:0] pos_idx;
    idx_o   = '0;
    found_o = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      pos     = (32'(ptr_i) + k) % NumReq;
      pos_idx = IdxW'(pos);
      if (!found_o && req_i[pos_idx]) begin
        idx_o   = pos_idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ requesters.
// Define FIFO_ARB_PRIORITY_EN to give requester 0 absolute priority at arbitration.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned SIZE      = 8,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      request,
  input  logic [NUM_REQ*SIZE-1:0] req_data,
  input  logic                    full_flag,
  input  logic                    almost_full_flag,
  output logic [NUM_REQ-1:0]      accept,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    valid_write,
  output logic [SIZE-1:0]         write_data,
  output logic                    busy
);

  localparam int unsigned ReqIdxW = req_idx_w(NUM_REQ);
  localparam int unsigned BeatW   = beat_w(BURST_LEN);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ReqIdxW-1:0] owner_q, owner_d;
  logic [ReqIdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic               valid_q, valid_d;
  logic [SIZE-1:0]    wdata_q, wdata_d;

  logic [NUM_REQ-1:0] scan_req;
  logic [ReqIdxW-1:0] sel_idx;
  logic               sel_found;
  logic               pick_zero;
  logic [ReqIdxW-1:0] next_ptr;
  logic [ReqIdxW-1:0] end_ptr;
  logic               can_write;
  logic               owner_req;
  logic               last_beat;
  logic [SIZE-1:0]    owner_word;

  // The registered write already in flight may consume the last free slot.
  assign can_write  = !full_flag && !(almost_full_flag && valid_q);
  assign owner_req  = request[owner_q];
  assign owner_word = req_data[32'(owner_q)*SIZE +: SIZE];
  assign last_beat  = (beat_q == BeatW'(BURST_LEN - 1));
  assign next_ptr   = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;

`ifdef FIFO_ARB_PRIORITY_EN
  assign scan_req  = {request[NUM_REQ-1:1], 1'b0};
  assign pick_zero = request[0];
  assign end_ptr   = (owner_q == '0) ? rr_ptr_q : next_ptr;
`else
  assign scan_req  = request;
  assign pick_zero = 1'b0;
  assign end_ptr   = next_ptr;
`endif

  rr_select #(
    .NumReq(NUM_REQ),
    .IdxW  (ReqIdxW)
  ) u_rr_select (
    .req_i  (scan_req),
    .ptr_i  (rr_ptr_q),
    .idx_o  (sel_idx),
    .found_o(sel_found)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    valid_d  = 1'b0;
    wdata_d  = wdata_q;
    accept   = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_zero) begin
          owner_d = '0;
          grant_d = NUM_REQ'(1);
          beat_d  = '0;
          state_d = BURST;
        end else if (sel_found) begin
          owner_d = sel_idx;
          grant_d = NUM_REQ'(1) << sel_idx;
          beat_d  = '0;
          state_d = BURST;
        end
      end

      BURST: begin
        if (owner_req && can_write) begin
          accept  = grant_q;
          wdata_d = owner_word;
          valid_d = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (last_beat) begin
            rr_ptr_d = end_ptr;
            grant_d  = '0;
            state_d  = IDLE;
          end
        end else if (!owner_req) begin
          rr_ptr_d = end_ptr;
          grant_d  = '0;
          state_d  = IDLE;
        end else begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (!owner_req) begin
          rr_ptr_d = end_ptr;
          grant_d  = '0;
          state_d  = IDLE;
        end else if (can_write) begin
          state_d = BURST;
        end
      end

      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      valid_q  <= valid_d;
      wdata_q  <= wdata_d;
    end
  end

  assign grant       = grant_q;
  assign valid_write = valid_q;
  assign write_data  = wdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (SIZE=8, NUM_REQ=4, BURST_LEN=4).
module tb_fifo_write_arbiter;

  logic        clock;
  logic        reset_n;
  logic [3:0]  request;
  logic [31:0] req_data;
  logic        full_flag;
  logic        almost_full_flag;
  logic [3:0]  accept;
  logic [3:0]  grant;
  logic        valid_write;
  logic [7:0]  write_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fifo_write_arbiter #(
    .SIZE     (8),
    .NUM_REQ  (4),
    .BURST_LEN(4)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .request         (request),
    .req_data        (req_data),
    .full_flag       (full_flag),
    .almost_full_flag(almost_full_flag),
    .accept          (accept),
    .grant           (grant),
    .valid_write     (valid_write),
    .write_data      (write_data),
    .busy            (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    request          = '0;
    req_data         = '0;
    full_flag        = 1'b0;
    almost_full_flag = 1'b0;

    // Reset state
    #12;
    check("rst_grant", grant, 0);
    check("rst_valid", valid_write, 0);
    check("rst_wdata", write_data, 0);
    check("rst_busy", busy, 0);
    check("rst_accept", accept, 0);
    reset_n = 1'b1;
    tick();

    // Single requester, 6 words: burst of 4, one idle cycle, then 2
    request       = 4'b0001;
    req_data[7:0] = 8'hA0;
    #1;
    check("t1_idle_accept", accept, 0);
    tick();
    check("t1_grant", grant, 4'b0001);
    check("t1_busy", busy, 1);
    check("t1_first_valid", valid_write, 0);
    for (int k = 0; k < 4; k++) begin
      check("t1_accept", accept, 4'b0001);
      tick();
      check("t1_valid", valid_write, 1);
      check("t1_wdata", write_data, 32'hA0 + 32'(k));
      req_data[7:0] = 8'(8'hA1 + k);
    end
    check("t1_end_grant", grant, 0);
    check("t1_end_busy", busy, 0);
    check("t1_end_accept", accept, 0);
    tick();
    check("t1_regrant", grant, 4'b0001);
    check("t1_gap_valid", valid_write, 0);
    for (int k = 0; k < 2; k++) begin
      check("t1b_accept", accept, 4'b0001);
      tick();
      check("t1b_valid", valid_write, 1);
      check("t1b_wdata", write_data, 32'hA4 + 32'(k));
      req_data[7:0] = 8'(8'hA5 + k);
    end
    request = 4'b0000;
    #1;
    check("t1_drop_accept", accept, 0);
    tick();
    check("t1_drop_busy", busy, 0);
    check("t1_drop_valid", valid_write, 0);

    // Reset pulse so round-robin starts from pointer 0
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;

    // Round-robin fairness: order 0,1,2,3,0 with 4 accepts each
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    request  = 4'b1111;
    for (int gi = 0; gi < 5; gi++) begin
      int g;
      g = gi % 4;
      #1;
      check("rr_idle_grant", grant, 0);
      check("rr_idle_accept", accept, 0);
      tick();
      check("rr_grant", grant, 32'(1) << g);
      for (int b = 0; b < 4; b++) begin
        check("rr_accept", accept, 32'(1) << g);
        tick();
        check("rr_valid", valid_write, 1);
        check("rr_wdata", write_data, 32'h10 * (32'(g) + 1));
      end
    end
    request = 4'b0000;
    tick();
    check("rr_done_busy", busy, 0);

    // Full throttle after 2 beats (pointer is now 1)
    request = 4'b0010;
    tick();
    check("full_grant", grant, 4'b0010);
    for (int b = 0; b < 2; b++) begin
      check("full_pre_accept", accept, 4'b0010);
      tick();
    end
    full_flag = 1'b1;
    #1;
    check("full_no_accept", accept, 0);
    tick();
    check("full_hold_valid", valid_write, 0);
    check("full_hold_busy", busy, 1);
    check("full_hold_grant", grant, 4'b0010);
    tick();
    check("full_hold2_accept", accept, 0);
    check("full_hold2_valid", valid_write, 0);
    full_flag = 1'b0;
    #1;
    check("hold_release_accept", accept, 0);
    tick();
    for (int b = 0; b < 2; b++) begin
      check("full_post_accept", accept, 4'b0010);
      tick();
      check("full_post_valid", valid_write, 1);
      check("full_post_wdata", write_data, 32'h20);
    end
    check("full_end_grant", grant, 0);
    request = 4'b0000;
    tick();

    // Almost-full: no back-to-back writes (pointer is now 2)
    almost_full_flag = 1'b1;
    request          = 4'b0100;
    tick();
    check("af_grant", grant, 4'b0100);
    check("af_first_accept", accept, 4'b0100);
    tick();
    check("af_valid", valid_write, 1);
    check("af_wdata", write_data, 32'h30);
    check("af_block", accept, 0);
    tick();
    check("af_no_b2b", valid_write, 0);
    check("af_hold_accept", accept, 0);
    tick();
    check("af_resume_accept", accept, 4'b0100);
    tick();
    check("af_resume_valid", valid_write, 1);
    almost_full_flag = 1'b0;
    request          = 4'b0000;
    #1;
    check("af_drop_accept", accept, 0);
    tick();
    check("af_end_busy", busy, 0);
    check("af_end_valid", valid_write, 0);

    // Early release by requester 3, pointer wraps to 0
    req_data[31:24] = 8'h44;
    req_data[7:0]   = 8'h11;
    request         = 4'b1001;
    tick();
    check("er_grant", grant, 4'b1000);
    check("er_accept", accept, 4'b1000);
    tick();
    check("er_wdata", write_data, 32'h44);
    request = 4'b0001;
    #1;
    check("er_nonowner_accept", accept, 0);
    tick();
    check("er_idle_busy", busy, 0);
    check("er_idle_grant", grant, 0);
    check("er_idle_valid", valid_write, 0);
    tick();
    check("er_wrap_grant", grant, 4'b0001);
    check("er_wrap_accept", accept, 4'b0001);
    tick();
    check("er_wrap_valid", valid_write, 1);
    check("er_wrap_wdata", write_data, 32'h11);

    // Asynchronous reset mid-burst
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_grant", grant, 0);
    check("ar_valid", valid_write, 0);
    check("ar_busy", busy, 0);
    check("ar_wdata", write_data, 0);
    request = 4'b0000;
    reset_n = 1'b1;
    tick();
    check("ar_post_busy", busy, 0);

    // Priority check: move pointer to 2, then requesters 0 and 2 pending
    request = 4'b0010;
    tick();
    check("pr_setup_grant", grant, 4'b0010);
    tick();
    request = 4'b0000;
    tick();
    check("pr_setup_idle", busy, 0);
    request = 4'b0101;
    tick();
`ifdef FIFO_ARB_PRIORITY_EN
    check("pr_first_grant", grant, 4'b0001);
    tick();
    request = 4'b0100;
    tick();
    check("pr_idle", busy, 0);
    tick();
    check("pr_ptr_kept_grant", grant, 4'b0100);
`else
    check("pr_first_grant", grant, 4'b0100);
`endif
    request = 4'b0000;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
